// File: rtl/uart_bus_pkg.sv
// Shared definitions for UART-facing register bridges: state encoding,
// command-byte layout and timer sizing.
package uart_bus_pkg;

    localparam int unsigned CMD_WRITE_BIT    = 7;
    localparam logic [7:0]  ERR_BYTE_DEFAULT = 8'hEE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WR_REQ   = 3'd2,
        RD_REQ   = 3'd3,
        SEND     = 3'd4
    } state_e;

    // Counter width able to hold LIMIT-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating clear/enable counter with a registered terminal-count flag.
// tc_o is high while the count equals LIMIT-1.
module timeout_counter
    import uart_bus_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetq,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W    = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tc_q;

    // Next count: clear wins, otherwise count up and hold at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register; the flag is registered from the next count so it tracks cnt_q.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command parser driving an 8-bit register bus.
// Command byte: bit7 set = write (followed by a data byte), clear = read;
// bits 6:0 = register address. Reads answer with one transmit byte.
module uart_reg_bridge
    import uart_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 600_000,
    parameter int unsigned ACK_CLKS     = 255,
    parameter logic [7:0]  ERR_BYTE     = ERR_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       uart_rd,
    input  logic       tx_busy,
    output logic       uart_wr,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       cmd_error
);

    state_e     state_q;
    logic       uart_rd_q;
    logic       rd_dly_q;
    logic       uart_wr_q;
    logic [7:0] tx_data_q;
    logic [6:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic       cmd_error_q;

    logic       byte_tc;
    logic       ack_tc;
    logic       rx_take_c;
    logic       byte_tmr_en_c;
    logic       ack_tmr_en_c;

    // A byte may be taken unless a read strobe is in flight or just finished.
    assign rx_take_c     = rx_valid && !uart_rd_q && !rd_dly_q;
    // Timers run only in their own state and sit cleared everywhere else.
    assign byte_tmr_en_c = (state_q == GET_DATA);
    assign ack_tmr_en_c  = (state_q == WR_REQ) || (state_q == RD_REQ);

    timeout_counter #(.LIMIT(TIMEOUT_CLKS)) u_byte_tmr (
        .clk    (clk),
        .resetq (resetq),
        .clr_i  (!byte_tmr_en_c),
        .en_i   (byte_tmr_en_c),
        .tc_o   (byte_tc)
    );

    timeout_counter #(.LIMIT(ACK_CLKS)) u_ack_tmr (
        .clk    (clk),
        .resetq (resetq),
        .clr_i  (!ack_tmr_en_c),
        .en_i   (ack_tmr_en_c),
        .tc_o   (ack_tc)
    );

    // Command FSM; the byte is captured on the cycle its uart_rd strobe is high.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q     <= IDLE;
            uart_rd_q   <= 1'b0;
            rd_dly_q    <= 1'b0;
            uart_wr_q   <= 1'b0;
            tx_data_q   <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            uart_rd_q   <= 1'b0;
            uart_wr_q   <= 1'b0;
            cmd_error_q <= 1'b0;
            rd_dly_q    <= uart_rd_q;
            unique case (state_q)
                IDLE: begin
                    if (uart_rd_q) begin
                        reg_addr_q <= rx_data[6:0];
                        if (rx_data[CMD_WRITE_BIT]) begin
                            state_q <= GET_DATA;
                        end else begin
                            reg_re_q <= 1'b1;
                            state_q  <= RD_REQ;
                        end
                    end else if (rx_take_c) begin
                        uart_rd_q <= 1'b1;
                    end
                end
                GET_DATA: begin
                    // A byte seen on the timeout cycle still wins.
                    if (uart_rd_q) begin
                        reg_wdata_q <= rx_data;
                        reg_we_q    <= 1'b1;
                        state_q     <= WR_REQ;
                    end else if (rx_take_c) begin
                        uart_rd_q <= 1'b1;
                    end else if (byte_tc) begin
                        cmd_error_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (reg_ack) begin
                        reg_we_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (ack_tc) begin
                        reg_we_q    <= 1'b0;
                        cmd_error_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (reg_ack) begin
                        tx_data_q <= reg_rdata;
                        reg_re_q  <= 1'b0;
                        state_q   <= SEND;
                    end else if (ack_tc) begin
                        tx_data_q   <= ERR_BYTE;
                        cmd_error_q <= 1'b1;
                        reg_re_q    <= 1'b0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    // tx_busy lags uart_wr by a cycle, so never fire twice back to back.
                    if (!tx_busy && !uart_wr_q) begin
                        uart_wr_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uart_rd   = uart_rd_q;
    assign uart_wr   = uart_wr_q;
    assign tx_data   = tx_data_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: stimulus pushes expected register
// accesses and transmit bytes; a monitor pops and compares on DUT activity.
module tb_uart_reg_bridge;

    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned ACK     = 255;
    localparam logic [7:0]  ERRB    = 8'hEE;

    logic       clk;
    logic       resetq;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       uart_rd;
    logic       tx_busy;
    logic       uart_wr;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       cmd_error;
    logic       tx_busy_model;
    logic       tx_busy_force;

    assign tx_busy = tx_busy_model | tx_busy_force;

    uart_reg_bridge #(
        .TIMEOUT_CLKS (TIMEOUT),
        .ACK_CLKS     (ACK),
        .ERR_BYTE     (ERRB)
    ) dut (
        .clk       (clk),
        .resetq    (resetq),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .uart_rd   (uart_rd),
        .tx_busy   (tx_busy),
        .uart_wr   (uart_wr),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .cmd_error (cmd_error)
    );

    typedef struct {
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         len;      // expected request window length, -1 = unchecked
    } req_t;

    typedef struct {
        int         d;        // ack delay in cycles after request rise, -1 = never
        logic [7:0] rdata;
    } ack_t;

    req_t       req_q[$];
    ack_t       ack_q[$];
    logic [7:0] tx_q[$];

    int checks     = 0;
    int errors     = 0;
    int bytes_sent = 0;
    int rd_pulses  = 0;
    int err_seen   = 0;
    int err_exp    = 0;

    // monitor state
    bit   in_win    = 1'b0;
    int   win_len   = 0;
    req_t cur;
    int   cyc       = 0;
    int   last_wr   = -100;
    logic prev_busy = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what one command should produce on the bus and UART.
    task automatic expect_access(input bit we, input logic [6:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] rdata, input int d);
        req_t r;
        ack_t a;
        bit   acked;
        acked   = (d >= 0) && (d < int'(ACK));
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.len   = acked ? d + 1 : int'(ACK);
        req_q.push_back(r);
        a.d     = d;
        a.rdata = rdata;
        ack_q.push_back(a);
        if (!we) tx_q.push_back(acked ? rdata : ERRB);
        if (!acked) err_exp++;
    endtask

    // buart receive side: present a byte once the previous one was taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rx_byte_taken_in_time", 32'(n < 3000), 32'd1);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        bytes_sent++;
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] data, input int d);
        expect_access(1'b1, addr, data, 8'($urandom), d);
        send_byte({1'b1, addr});
        send_byte(data);
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [7:0] rdata, input int d);
        expect_access(1'b0, addr, 8'h00, rdata, d);
        send_byte({1'b0, addr});
    endtask

    // Write command with no data byte: expect only a cmd_error.
    task automatic do_abort(input logic [6:0] addr);
        int n = 0;
        err_exp++;
        send_byte({1'b1, addr});
        while (rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_cmd_taken", 32'(n < 3000), 32'd1);
        repeat (TIMEOUT + 5) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((req_q.size() != 0 || tx_q.size() != 0 || rx_valid || reg_we || reg_re) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < 5000), 32'd1);
        repeat (30) @(negedge clk);
    endtask

    // buart consumes the held byte on the edge that sees uart_rd.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_rd && rx_valid) begin
                @(posedge clk);
                #1 rx_valid = 1'b0;
            end
        end
    end

    // buart transmit side: busy rises a cycle late and lasts a few cycles.
    initial begin
        tx_busy_model = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_wr) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_busy_model = 1'b1;
                repeat ($urandom_range(3, 12)) @(posedge clk);
                #1 tx_busy_model = 1'b0;
            end
        end
    end

    // Register-bus responder driven from the ack queue.
    initial begin
        ack_t a;
        int   n;
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (resetq && (reg_we || reg_re)) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_model: request with nothing queued, we=%0b re=%0b", reg_we, reg_re);
                    n = 0;
                    while ((reg_we || reg_re) && n < int'(ACK) + 20) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    a = ack_q.pop_front();
                    if (a.d >= 0) begin
                        repeat (a.d) @(negedge clk);
                        reg_rdata = a.rdata;
                        reg_ack   = 1'b1;
                        @(negedge clk);
                        reg_ack   = 1'b0;
                    end else begin
                        n = 0;
                        while ((reg_we || reg_re) && n < int'(ACK) + 20) begin
                            @(negedge clk);
                            n++;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare every request window and transmit strobe with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetq) begin
                in_win    = 1'b0;
                prev_busy = tx_busy;
            end else begin
                if (reg_we || reg_re) begin
                    if (!in_win) begin
                        in_win  = 1'b1;
                        win_len = 1;
                        check("req_exclusive", 32'(reg_we & reg_re), 32'd0);
                        if (req_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_req: we=%0b re=%0b addr=0x%0h, expected none", reg_we, reg_re, reg_addr);
                            cur.len = -1;
                        end else begin
                            cur = req_q.pop_front();
                            check("req_kind_we", 32'(reg_we), 32'(cur.we));
                            check("req_addr", 32'(reg_addr), 32'(cur.addr));
                            if (cur.we) check("req_wdata", 32'(reg_wdata), 32'(cur.wdata));
                        end
                    end else begin
                        win_len++;
                    end
                end else if (in_win) begin
                    in_win = 1'b0;
                    if (cur.len > 0) check("req_len", 32'(win_len), 32'(cur.len));
                end
                if (uart_rd) rd_pulses++;
                if (cmd_error) err_seen++;
                if (uart_wr) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: tx_data=0x%0h, expected no transmit", tx_data);
                    end else begin
                        check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
                    end
                    check("tx_idle_before_wr", 32'(prev_busy), 32'd0);
                    check("wr_spacing_ge2", 32'((cyc - last_wr) >= 2), 32'd1);
                    last_wr = cyc;
                end
                prev_busy = tx_busy;
            end
        end
    end

    // Main stimulus.
    initial begin
        req_t r;
        ack_t a;
        int   n;
        int   op;
        int   d;
        resetq        = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        tx_busy_force = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reg_bus", 32'({reg_addr, reg_wdata, reg_we, reg_re}), 32'd0);
        check("rst_uart", 32'({uart_rd, uart_wr, tx_data}), 32'd0);
        check("rst_cmd_error", 32'(cmd_error), 32'd0);
        @(negedge clk);
        resetq = 1'b1;
        repeat (3) @(negedge clk);

        // directed: write, read, inter-byte timeout, ack timeout
        do_write(7'h05, 8'h3C, 3);
        wait_idle();
        check("write_rd_pulses", 32'(rd_pulses), 32'd2);
        do_read(7'h12, 8'hA7, 5);
        do_abort(7'h01);
        do_read(7'h01, 8'h6B, 4);
        do_read(7'h07, 8'h00, -1);
        wait_idle();

        // transmitter back-pressure
        @(posedge clk);
        #1 tx_busy_force = 1'b1;
        do_read(7'h02, 8'h5A, 2);
        repeat (100) @(posedge clk);
        #1 tx_busy_force = 1'b0;
        @(negedge clk);
        check("wr_held_while_busy", 32'(uart_wr), 32'd0);
        @(negedge clk);
        check("wr_on_busy_release", 32'(uart_wr), 32'd1);
        do_read(7'h21, 8'hC3, 1);
        do_read(7'h22, 8'h3D, 0);
        wait_idle();

        // randomized command mix
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 9));
            d  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
            if (op == 0) begin
                do_abort(7'($urandom));
            end else if (op < 5) begin
                do_write(7'($urandom), 8'($urandom), d);
            end else begin
                do_read(7'($urandom), 8'($urandom), d);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // asynchronous reset in the middle of a write access
        r.we    = 1'b1;
        r.addr  = 7'h33;
        r.wdata = 8'h44;
        r.len   = -1;
        req_q.push_back(r);
        a.d     = -1;
        a.rdata = 8'h00;
        ack_q.push_back(a);
        send_byte(8'hB3);
        send_byte(8'h44);
        n = 0;
        while (!reg_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_we_seen", 32'(reg_we), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetq = 1'b0;
        #1;
        check("async_rst_we", 32'(reg_we), 32'd0);
        check("async_rst_bus", 32'({reg_addr, reg_wdata}), 32'd0);
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        do_read(7'h10, 8'h55, 3);
        wait_idle();

        check("rd_pulse_count", 32'(rd_pulses), 32'(bytes_sent));
        check("cmd_error_count", 32'(err_seen), 32'(err_exp));
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
